// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and helpers for the reset sequencer.
//   rst_seq_state_t : sequencer FSM states
//   STAGE_IDX_W     : width of the stage index (covers up to 8 outputs)
//   clog2()         : ceiling log2 for counter widths (minimum 1)
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    HOLD   = 2'd1,
    REL    = 2'd2,
    RUN    = 2'd3
  } rst_seq_state_t;

  localparam int STAGE_IDX_W = 3;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// rst_sync_cell: reset deassertion synchronizer.
//   Chain of STAGES flops, asynchronously set by rst, shifting in 0 once
//   rst is low, so the release reaches the clock domain synchronously.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous, active-high reset (sets the chain)
//   rst_sync out  synchronized reset, high until STAGES edges after rst falls
module rst_sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_sync
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_q <= '1;
    else     chain_q <= {chain_q[STAGES-2:0], 1'b0};
  end

  assign rst_sync = chain_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: reset generator/sequencer for one clock domain.
//   Asserts all downstream resets asynchronously on rst, then releases them
//   synchronously one stage at a time (0..NUM_OUT-1), gated by a hold time
//   and per-stage acknowledgements. sw_rst_req re-runs the sequence from HOLD.
// Optional feature: define RST_SEQ_ACK_TIMEOUT_EN to add a per-stage ack
//   timeout (sticky err, full retry). Without it REL waits forever, err = 0.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous, active-high reset
//   sw_rst_req   in   synchronous soft-reset request (level)
//   stage_ack    in   per-stage ready, sampled only while that stage releases
//   rst_out      out  sequenced resets, async assert / sync deassert
//   busy         out  high in every state except RUN
//   all_released out  high only in RUN
//   err          out  sticky ack-timeout flag
//
// state  | meaning
// ASSERT | all resets high, waiting for the synchronized release
// HOLD   | all resets high, counting HOLD_CYCLES edges
// REL    | stage idx released, waiting for stage_ack[idx]
// RUN    | every stage released
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_OUT     = 3,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  input  logic [NUM_OUT-1:0] stage_ack,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               busy,
  output logic               all_released,
  output logic               err
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync
    $error("rst_sequencer: SYNC_STAGES must be 2..4");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("rst_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_chk_num
    $error("rst_sequencer: NUM_OUT must be 1..8");
  end
  if (ACK_TIMEOUT < 1) begin : g_chk_ack
    $error("rst_sequencer: ACK_TIMEOUT must be >= 1");
  end

`ifdef RST_SEQ_ACK_TIMEOUT_EN
  localparam int CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
`else
  localparam int CNT_MAX = HOLD_CYCLES;
`endif
  localparam int CNT_W = clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [STAGE_IDX_W-1:0] IDX_LAST  = STAGE_IDX_W'(NUM_OUT - 1);

  rst_seq_state_t           state_q, state_d;
  logic [STAGE_IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_OUT-1:0]       rst_out_q, rst_out_d;
  logic                     rst_sync;
  logic                     ack_cur;
  logic                     hold_done;

`ifdef RST_SEQ_ACK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  logic err_q, err_d;
`endif

  rst_sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .rst_sync (rst_sync)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    hold_done = 1'b0;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    err_d     = err_q;
`endif

    ack_cur = 1'b0;
    for (int i = 0; i < NUM_OUT; i++)
      if (idx_q == STAGE_IDX_W'(i)) ack_cur = stage_ack[i];

    case (state_q)
      ASSERT: begin
        rst_out_d = '1;
        cnt_d     = '0;
        // The edge that first samples the released chain is hold edge 1, so
        // rst_out[0] falls SYNC_STAGES+HOLD_CYCLES edges after rst drops.
        if (!rst_sync) begin
          if (HOLD_CYCLES == 1) hold_done = 1'b1;
          else begin
            state_d = HOLD;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) hold_done = 1'b1;
        else                    cnt_d = cnt_q + CNT_W'(1);
      end
      REL: begin
        if (ack_cur) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = RUN;
          else begin
            idx_d = idx_q + STAGE_IDX_W'(1);
            for (int i = 1; i < NUM_OUT; i++)
              if (idx_q == STAGE_IDX_W'(i - 1)) rst_out_d[i] = 1'b0;
          end
        end
`ifdef RST_SEQ_ACK_TIMEOUT_EN
        else if (cnt_q == ACK_LAST) begin
          err_d     = 1'b1;
          rst_out_d = '1;
          state_d   = HOLD;
          idx_d     = '0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RUN: ;
      default: state_d = ASSERT;
    endcase

    if (hold_done) begin
      rst_out_d[0] = 1'b0;
      state_d      = REL;
      idx_d        = '0;
      cnt_d        = '0;
    end

    // Soft reset overrides any ack or timeout sampled on the same edge.
    if (sw_rst_req && state_q != ASSERT) begin
      rst_out_d = '1;
      state_d   = HOLD;
      idx_d     = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ASSERT;
      idx_q     <= '0;
      cnt_q     <= '0;
      rst_out_q <= '1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
    end
  end

`ifdef RST_SEQ_ACK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign rst_out      = rst_out_q;
  assign busy         = (state_q != RUN);
  assign all_released = (state_q == RUN);

endmodule
